// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the DDRAM port arbiter and its write FIFO.
package ddram_arb_pkg;

  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;  // 101 bits per queued write

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_CMD,
    ST_RD_DATA
  } arb_state_e;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [BE_W-1:0]   be;
  } wr_entry_t;

  // A requested burst of zero beats is issued as a single beat.
  function automatic logic [7:0] eff_burst(input logic [7:0] burst);
    return (burst == 8'd0) ? 8'd1 : burst;
  endfunction

endpackage

// File: rtl/ddram_port_arbiter_if.sv
// Avalon-style DDRAM port: the arbiter is the master, the memory controller the slave.
interface ddram_port_arbiter_if;
  import ddram_arb_pkg::*;

  logic              DDRAM_CLK;
  logic              DDRAM_BUSY;
  logic [7:0]        DDRAM_BURSTCNT;
  logic [ADDR_W-1:0] DDRAM_ADDR;
  logic [DATA_W-1:0] DDRAM_DIN;
  logic [BE_W-1:0]   DDRAM_BE;
  logic              DDRAM_WE;
  logic              DDRAM_RD;
  logic [DATA_W-1:0] DDRAM_DOUT;
  logic              DDRAM_DOUT_READY;

  modport master (
    output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
  );

  modport slave (
    input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
  );

endinterface

// File: rtl/ddram_wr_fifo.sv
// Write-command FIFO with a registered head: an entry pushed into an empty
// FIFO appears at the output (dout_valid_o) one cycle after the push.
module ddram_wr_fifo
  import ddram_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  wr_entry_t        din_i,
  input  logic             pop_i,
  output wr_entry_t        dout_o,
  output logic             dout_valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  wr_entry_t          head_q;
  logic               head_valid_q;
  logic               push_ok, pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && (count_q != '0);
  assign rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
  end

  // Entry storage.
  // NOTE: the storage array has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers, count and the registered head. The head becomes valid only for
  // entries that were already stored before this edge and are not being popped.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= mem_q[rd_ptr_d];
      head_valid_q <= (count_q != '0) && !(pop_ok && (count_q == CNT_W'(1)));
    end
  end

  assign dout_o       = head_q;
  assign dout_valid_o = head_valid_q;
  assign count_o      = count_q;

endmodule

// File: rtl/ddram_port_arbiter.sv
// Shares the DDRAM port between a FIFO-buffered write stream and a single
// burst-read client. Writes are single-beat; reads return a burst of beats.
module ddram_port_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIO_MARGIN = 2
) (
  input  logic                CLK_VIDEO,
  input  logic                reset,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_din,
  input  logic [BE_W-1:0]     wr_be,
  output logic                wr_full,
  output logic                wr_ovf,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [7:0]          rd_burst,
  output logic                rd_ack,
  output logic                rd_busy,
  output logic [DATA_W-1:0]   rd_dout,
  output logic                rd_dout_ready,
  ddram_port_arbiter_if.master ddram
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] PRIO_THR = CNT_W'(FIFO_DEPTH - PRIO_MARGIN);

  wr_entry_t         push_entry, head;
  logic              head_valid, fifo_full, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              grant_wr, grant_rd, beat_in;

  arb_state_e        state_q;
  grant_e            last_grant_q;
  logic              we_q, rd_q, rd_ack_q, rd_busy_q, rd_last_q, rd_dout_ready_q, wr_ovf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q, rd_dout_q;
  logic [BE_W-1:0]   be_q;
  logic [7:0]        burstcnt_q, beat_q;

  assign push_entry = '{addr: wr_addr, din: wr_din, be: wr_be};
  assign fifo_pop   = (state_q == ST_WR) && !ddram.DDRAM_BUSY;
  assign beat_in    = ddram.DDRAM_DOUT_READY && (state_q == ST_RD_DATA);

  ddram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_wr_fifo (
    .clk          (CLK_VIDEO),
    .rst          (reset),
    .push_i       (wr_req),
    .din_i        (push_entry),
    .pop_i        (fifo_pop),
    .dout_o       (head),
    .dout_valid_o (head_valid),
    .full_o       (fifo_full),
    .count_o      (fifo_count)
  );

  // Grant choice for IDLE: a nearly full FIFO wins outright, ties alternate.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (head_valid && (fifo_count >= PRIO_THR)) begin
      grant_wr = 1'b1;
    end else if (head_valid && rd_req) begin
      if (last_grant_q == GRANT_RD) grant_wr = 1'b1;
      else                          grant_rd = 1'b1;
    end else if (head_valid) begin
      grant_wr = 1'b1;
    end else if (rd_req) begin
      grant_rd = 1'b1;
    end
  end

  // Command FSM with registered DDRAM outputs; outputs only change on a grant
  // or an accepting edge, so they stay stable while BUSY is high.
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_RD;
      we_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      be_q         <= '0;
      burstcnt_q   <= 8'd1;
      beat_q       <= 8'd0;
      rd_ack_q     <= 1'b0;
      rd_busy_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      rd_ack_q  <= 1'b0;
      rd_last_q <= 1'b0;
      // rd_busy covers the cycle in which the last beat is presented on rd_dout.
      if (rd_last_q) rd_busy_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_wr) begin
            addr_q       <= head.addr;
            din_q        <= head.din;
            be_q         <= head.be;
            burstcnt_q   <= 8'd1;
            we_q         <= 1'b1;
            last_grant_q <= GRANT_WR;
            state_q      <= ST_WR;
          end else if (grant_rd) begin
            addr_q       <= rd_addr;
            burstcnt_q   <= eff_burst(rd_burst);
            rd_q         <= 1'b1;
            last_grant_q <= GRANT_RD;
            state_q      <= ST_RD_CMD;
          end
        end
        ST_WR: begin
          if (!ddram.DDRAM_BUSY) begin
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RD_CMD: begin
          if (!ddram.DDRAM_BUSY) begin
            rd_q      <= 1'b0;
            rd_ack_q  <= 1'b1;
            rd_busy_q <= 1'b1;
            beat_q    <= 8'd0;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (ddram.DDRAM_DOUT_READY) begin
            beat_q <= beat_q + 8'd1;
            if (beat_q == burstcnt_q - 8'd1) begin
              rd_last_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read return: beats are registered and only accepted while a read is open.
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      rd_dout_q       <= '0;
      rd_dout_ready_q <= 1'b0;
    end else begin
      rd_dout_ready_q <= beat_in;
      if (beat_in) rd_dout_q <= ddram.DDRAM_DOUT;
    end
  end

  // Sticky overflow flag for pushes dropped while the FIFO is full.
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset)                   wr_ovf_q <= 1'b0;
    else if (wr_req && fifo_full) wr_ovf_q <= 1'b1;
  end

  assign wr_full              = fifo_full;
  assign wr_ovf               = wr_ovf_q;
  assign rd_ack               = rd_ack_q;
  assign rd_busy              = rd_busy_q;
  assign rd_dout              = rd_dout_q;
  assign rd_dout_ready        = rd_dout_ready_q;
  assign ddram.DDRAM_CLK      = CLK_VIDEO;
  assign ddram.DDRAM_BURSTCNT = burstcnt_q;
  assign ddram.DDRAM_ADDR     = addr_q;
  assign ddram.DDRAM_DIN      = din_q;
  assign ddram.DDRAM_BE       = be_q;
  assign ddram.DDRAM_WE       = we_q;
  assign ddram.DDRAM_RD       = rd_q;

endmodule

// File: tb/tb_ddram_port_arbiter.sv
// Directed bench for ddram_port_arbiter: write latency, BUSY hold, overflow,
// burst reads, zero-length burst, tie alternation, write priority and reset.
module tb_ddram_port_arbiter;
  import ddram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [28:0] wr_addr = '0;
  logic [63:0] wr_din = '0;
  logic [7:0]  wr_be = '0;
  logic        wr_full, wr_ovf;
  logic        rd_req = 1'b0;
  logic [28:0] rd_addr = '0;
  logic [7:0]  rd_burst = '0;
  logic        rd_ack, rd_busy, rd_dout_ready;
  logic [63:0] rd_dout;

  always #5 clk = ~clk;

  ddram_port_arbiter_if ddram ();

  ddram_port_arbiter #(
    .FIFO_DEPTH  (8),
    .PRIO_MARGIN (2)
  ) dut (
    .CLK_VIDEO     (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_din        (wr_din),
    .wr_be         (wr_be),
    .wr_full       (wr_full),
    .wr_ovf        (wr_ovf),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_burst      (rd_burst),
    .rd_ack        (rd_ack),
    .rd_busy       (rd_busy),
    .rd_dout       (rd_dout),
    .rd_dout_ready (rd_dout_ready),
    .ddram         (ddram)
  );

  int n_checks = 0;
  int n_bad    = 0;
  int ack_cnt  = 0;

  // Accepted commands in issue order: {is_write, addr}
  logic [29:0] cmd_log[$];
  logic [63:0] din_log[$];
  logic [7:0]  be_log[$];
  logic [7:0]  bc_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs only change 1 time unit after a rising edge, so the values seen at
  // the falling edge decide whether the next rising edge accepts a command.
  always @(negedge clk) begin
    if (!reset) begin
      if (ddram.DDRAM_WE && !ddram.DDRAM_BUSY) begin
        cmd_log.push_back({1'b1, ddram.DDRAM_ADDR});
        din_log.push_back(ddram.DDRAM_DIN);
        be_log.push_back(ddram.DDRAM_BE);
        bc_log.push_back(ddram.DDRAM_BURSTCNT);
      end
      if (ddram.DDRAM_RD && !ddram.DDRAM_BUSY) begin
        cmd_log.push_back({1'b0, ddram.DDRAM_ADDR});
        bc_log.push_back(ddram.DDRAM_BURSTCNT);
      end
      if (rd_ack) ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_din  = d;
    wr_be   = b;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    ddram.DDRAM_DOUT_READY = 1'b1;
    ddram.DDRAM_DOUT       = d;
    tick();
    ddram.DDRAM_DOUT_READY = 1'b0;
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    din_log.delete();
    be_log.delete();
    bc_log.delete();
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_log.size() >= n) break;
      tick();
    end
    check(tag, 64'(cmd_log.size()), 64'(n));
  endtask

  task automatic wait_ack(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rd_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic check_cmd(input string tag, input int idx, input logic [29:0] exp);
    logic [29:0] got;
    got = '1;
    if (cmd_log.size() > idx) got = cmd_log[idx];
    check(tag, 64'(got), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_base;
    ddram.DDRAM_BUSY       = 1'b0;
    ddram.DDRAM_DOUT       = '0;
    ddram.DDRAM_DOUT_READY = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_we",       64'(ddram.DDRAM_WE), 64'd0);
    check("rst_rd",       64'(ddram.DDRAM_RD), 64'd0);
    check("rst_addr",     64'(ddram.DDRAM_ADDR), 64'd0);
    check("rst_din",      ddram.DDRAM_DIN, 64'd0);
    check("rst_be",       64'(ddram.DDRAM_BE), 64'd0);
    check("rst_burstcnt", 64'(ddram.DDRAM_BURSTCNT), 64'd1);
    check("rst_ack",      64'(rd_ack), 64'd0);
    check("rst_busy",     64'(rd_busy), 64'd0);
    check("rst_dready",   64'(rd_dout_ready), 64'd0);
    check("rst_dout",     rd_dout, 64'd0);
    check("rst_full",     64'(wr_full), 64'd0);
    check("rst_ovf",      64'(wr_ovf), 64'd0);
    reset = 1'b0;
    tick();

    // Single write: pushed at edge N, WE high after N+2, accepted at N+3
    clear_logs();
    push_word(29'h1234, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F);
    check("wr1_we_n", 64'(ddram.DDRAM_WE), 64'd0);
    tick();
    check("wr1_we_n1", 64'(ddram.DDRAM_WE), 64'd0);
    tick();
    check("wr1_we_n2",   64'(ddram.DDRAM_WE), 64'd1);
    check("wr1_addr",    64'(ddram.DDRAM_ADDR), 64'h1234);
    check("wr1_din",     ddram.DDRAM_DIN, 64'hA5A5_A5A5_A5A5_A5A5);
    check("wr1_be",      64'(ddram.DDRAM_BE), 64'h0F);
    check("wr1_bcnt",    64'(ddram.DDRAM_BURSTCNT), 64'd1);
    tick();
    check("wr1_we_n3",   64'(ddram.DDRAM_WE), 64'd0);
    check("wr1_count",   64'(cmd_log.size()), 64'd1);

    // Write held by BUSY for 5 cycles
    clear_logs();
    ddram.DDRAM_BUSY = 1'b1;
    push_word(29'h0055, 64'h0123_4567_89AB_CDEF, 8'hF0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_we",   64'(ddram.DDRAM_WE), 64'd1);
      check("hold_addr", 64'(ddram.DDRAM_ADDR), 64'h0055);
      check("hold_din",  ddram.DDRAM_DIN, 64'h0123_4567_89AB_CDEF);
      tick();
    end
    check("hold_none", 64'(cmd_log.size()), 64'd0);
    ddram.DDRAM_BUSY = 1'b0;
    tick();
    check("hold_we_off", 64'(ddram.DDRAM_WE), 64'd0);
    tick(); tick();
    check("hold_once", 64'(cmd_log.size()), 64'd1);

    // Overflow: 10 pushes with BUSY stuck high
    clear_logs();
    ddram.DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(29'h100 + 29'(i), 64'h1000 + 64'(i), 8'hFF);
      if (i == 6) check("ovf_full7", 64'(wr_full), 64'd0);
      if (i == 7) check("ovf_full8", 64'(wr_full), 64'd1);
      if (i == 7) check("ovf_flag8", 64'(wr_ovf), 64'd0);
      if (i == 8) check("ovf_flag9", 64'(wr_ovf), 64'd1);
    end
    ddram.DDRAM_BUSY = 1'b0;
    wait_log("ovf_drain", 8, 60);
    tick(); tick(); tick(); tick();
    check("ovf_exact", 64'(cmd_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_cmd("ovf_order", i, {1'b1, 29'h100 + 29'(i)});
    check("ovf_din7", (din_log.size() > 7) ? din_log[7] : 64'd0, 64'h1007);
    check("ovf_full_clr", 64'(wr_full), 64'd0);
    check("ovf_sticky", 64'(wr_ovf), 64'd1);

    // Burst read of 4 beats at 0x800
    ack_base = ack_cnt;
    rd_req = 1'b1; rd_addr = 29'h800; rd_burst = 8'd4;
    tick();
    check("rd4_rd",   64'(ddram.DDRAM_RD), 64'd1);
    check("rd4_addr", 64'(ddram.DDRAM_ADDR), 64'h800);
    check("rd4_bcnt", 64'(ddram.DDRAM_BURSTCNT), 64'd4);
    tick();
    check("rd4_ack",  64'(rd_ack), 64'd1);
    check("rd4_busy", 64'(rd_busy), 64'd1);
    check("rd4_rdoff", 64'(ddram.DDRAM_RD), 64'd0);
    rd_req = 1'b0;
    tick();
    check("rd4_ack_off", 64'(rd_ack), 64'd0);
    beat(64'hB0B0_0000_0000_0000);
    check("rd4_b0_rdy", 64'(rd_dout_ready), 64'd1);
    check("rd4_b0",     rd_dout, 64'hB0B0_0000_0000_0000);
    beat(64'hB0B0_0000_0000_0001);
    check("rd4_b1",     rd_dout, 64'hB0B0_0000_0000_0001);
    tick();
    check("rd4_gap_rdy", 64'(rd_dout_ready), 64'd0);
    beat(64'hB0B0_0000_0000_0002);
    check("rd4_b2",     rd_dout, 64'hB0B0_0000_0000_0002);
    check("rd4_b2_busy", 64'(rd_busy), 64'd1);
    beat(64'hB0B0_0000_0000_0003);
    check("rd4_b3_rdy", 64'(rd_dout_ready), 64'd1);
    check("rd4_b3",     rd_dout, 64'hB0B0_0000_0000_0003);
    check("rd4_b3_busy", 64'(rd_busy), 64'd1);
    beat(64'hDEAD_DEAD_DEAD_DEAD);
    check("rd4_done_busy", 64'(rd_busy), 64'd0);
    check("rd4_stray_rdy", 64'(rd_dout_ready), 64'd0);
    check("rd4_stray_dout", rd_dout, 64'hB0B0_0000_0000_0003);
    check("rd4_one_ack", 64'(ack_cnt - ack_base), 64'd1);

    // Zero-length burst behaves as one beat
    rd_req = 1'b1; rd_addr = 29'h40; rd_burst = 8'd0;
    tick();
    check("rd0_rd",   64'(ddram.DDRAM_RD), 64'd1);
    check("rd0_bcnt", 64'(ddram.DDRAM_BURSTCNT), 64'd1);
    tick();
    check("rd0_ack", 64'(rd_ack), 64'd1);
    rd_req = 1'b0;
    beat(64'hCAFE);
    check("rd0_rdy",  64'(rd_dout_ready), 64'd1);
    check("rd0_dout", rd_dout, 64'hCAFE);
    tick();
    check("rd0_busy_off", 64'(rd_busy), 64'd0);

    // Tie below the priority threshold: W0, then read, then remaining writes
    clear_logs();
    ddram.DDRAM_BUSY = 1'b1;
    push_word(29'h0A0, 64'hA0, 8'h01);
    tick(); tick();
    push_word(29'h0A1, 64'hA1, 8'h01);
    push_word(29'h0A2, 64'hA2, 8'h01);
    rd_req = 1'b1; rd_addr = 29'h900; rd_burst = 8'd1;
    ddram.DDRAM_BUSY = 1'b0;
    wait_ack("alt_ack", 20);
    rd_req = 1'b0;
    beat(64'h900);
    wait_log("alt_len", 4, 30);
    check_cmd("alt_0", 0, {1'b1, 29'h0A0});
    check_cmd("alt_1", 1, {1'b0, 29'h900});
    check_cmd("alt_2", 2, {1'b1, 29'h0A1});
    check_cmd("alt_3", 3, {1'b1, 29'h0A2});

    // Count at threshold after W0: priority write B1 precedes the read
    clear_logs();
    ddram.DDRAM_BUSY = 1'b1;
    push_word(29'h0B0, 64'hB0, 8'h01);
    tick(); tick();
    for (int i = 1; i < 7; i++) push_word(29'h0B0 + 29'(i), 64'hB0 + 64'(i), 8'h01);
    rd_req = 1'b1; rd_addr = 29'hA00; rd_burst = 8'd1;
    ddram.DDRAM_BUSY = 1'b0;
    wait_ack("prio_ack", 30);
    rd_req = 1'b0;
    beat(64'hA00);
    wait_log("prio_len", 8, 40);
    check_cmd("prio_0", 0, {1'b1, 29'h0B0});
    check_cmd("prio_1", 1, {1'b1, 29'h0B1});
    check_cmd("prio_2", 2, {1'b0, 29'hA00});
    check_cmd("prio_3", 3, {1'b1, 29'h0B2});
    check_cmd("prio_7", 7, {1'b1, 29'h0B6});

    // Asynchronous reset mid-write flushes the FIFO and clears wr_ovf
    clear_logs();
    ddram.DDRAM_BUSY = 1'b1;
    push_word(29'h0C0, 64'hC0, 8'h01);
    push_word(29'h0C1, 64'hC1, 8'h01);
    tick();
    check("mrst_we_pre", 64'(ddram.DDRAM_WE), 64'd1);
    reset = 1'b1;
    #1;
    check("mrst_we",   64'(ddram.DDRAM_WE), 64'd0);
    check("mrst_ovf",  64'(wr_ovf), 64'd0);
    check("mrst_bcnt", 64'(ddram.DDRAM_BURSTCNT), 64'd1);
    tick();
    reset = 1'b0;
    ddram.DDRAM_BUSY = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mrst_flush", 64'(cmd_log.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
